// File: rtl/snoop_arbiter.sv
// rtl/snoop_arbiter.sv - round-robin snoop bus arbiter with registered one-hot grant
// Optional hold-timeout release: define SNOOP_ARB_TIMEOUT_EN.
package cache_types;
  parameter int NUM_CACHE = 4;
endpackage

module snoop_arbiter #(
  parameter int NUM_NODES      = cache_types::NUM_CACHE,
  parameter int IDX            = $clog2(NUM_NODES),
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_NODES-1:0] req,
  input  logic [NUM_NODES-1:0] done,
  output logic [NUM_NODES-1:0] gnt,
  output logic                 gnt_valid,
  output logic [IDX-1:0]       gnt_idx,
  output logic                 timeout_err
);

  typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;

  state_t               state, state_nxt;
  logic [IDX-1:0]       ptr, ptr_nxt;
  logic [NUM_NODES-1:0] gnt_nxt;
  logic [IDX-1:0]       idx_nxt;
  logic                 valid_nxt;
  logic [IDX-1:0]       winner;
  logic                 found;
  logic                 timeout_hit;
  logic                 owner_done;

  // Walk the search order backwards so the last hit is the first node at or after ptr.
  always_comb begin
    int j;
    winner = '0;
    found  = 1'b0;
    j      = 0;
    for (int i = NUM_NODES - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % NUM_NODES;
      if (req[j]) begin
        winner = IDX'(j);
        found  = 1'b1;
      end
    end
  end

  assign owner_done = done[gnt_idx];

`ifdef SNOOP_ARB_TIMEOUT_EN
  logic [15:0] hold_cnt, hold_cnt_nxt;
  logic        terr_nxt;

  assign timeout_hit = (hold_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_comb begin
    hold_cnt_nxt = hold_cnt;
    terr_nxt     = 1'b0;
    if (state == IDLE) begin
      hold_cnt_nxt = '0;
    end else if (state == OWN) begin
      hold_cnt_nxt = hold_cnt + 16'd1;
      terr_nxt     = timeout_hit && !owner_done;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      hold_cnt    <= hold_cnt_nxt;
      timeout_err <= terr_nxt;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    valid_nxt = gnt_valid;
    idx_nxt   = gnt_idx;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        if (found) begin
          gnt_nxt   = NUM_NODES'(1) << winner;
          valid_nxt = 1'b1;
          idx_nxt   = winner;
          state_nxt = OWN;
        end
      end
      OWN: begin
        if (owner_done || timeout_hit) begin
          gnt_nxt   = '0;
          valid_nxt = 1'b0;
          idx_nxt   = '0;
          ptr_nxt   = (gnt_idx == IDX'(NUM_NODES - 1)) ? '0 : gnt_idx + IDX'(1);
          state_nxt = TURN;
        end
      end
      TURN: state_nxt = IDLE;
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        valid_nxt = 1'b0;
        idx_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_idx   <= '0;
      ptr       <= '0;
    end else begin
      state     <= state_nxt;
      gnt       <= gnt_nxt;
      gnt_valid <= valid_nxt;
      gnt_idx   <= idx_nxt;
      ptr       <= ptr_nxt;
    end
  end

  a_params: assert property (@(posedge clk)
    (NUM_NODES >= 2) && (NUM_NODES <= 16) && (TIMEOUT_CYCLES >= 2) && (TIMEOUT_CYCLES <= 65535));

  a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));

  a_consistent: assert property (@(posedge clk) disable iff (!rst_n)
    (gnt_valid == (|gnt)) &&
    (gnt == (gnt_valid ? (NUM_NODES'(1) << gnt_idx) : '0)) &&
    (gnt_valid || (gnt_idx == '0)));

endmodule

// File: tb/tb_snoop_arbiter.sv
// tb/tb_snoop_arbiter.sv - directed vector bench for snoop_arbiter (N=4)
module tb_snoop_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_idx;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;
  int edges  = 0;

  snoop_arbiter #(.NUM_NODES(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt), .gnt_valid(gnt_valid), .gnt_idx(gnt_idx), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] gnt;
    logic [1:0] idx;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [3:0] r, input logic [3:0] d);
    req  = r;
    done = d;
    @(posedge clk);
    edges++;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    done  = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Invariant monitor on the inactive edge
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if (!$onehot0(gnt) || (gnt_valid !== (|gnt)) ||
          (gnt_valid ? (gnt !== (4'b0001 << gnt_idx)) : (gnt_idx !== 2'd0))) begin
        errors++;
        $display("FAIL invariant gnt=%b gnt_valid=%b gnt_idx=%0d", gnt, gnt_valid, gnt_idx);
      end
    end
  end

  initial begin
    int fall_edge;
    int w;
    logic [3:0] exp_g;

    tbl[0]  = '{4'b0100, 4'b0000, 4'b0100, 2'd2};
    tbl[1]  = '{4'b0100, 4'b0000, 4'b0100, 2'd2};
    tbl[2]  = '{4'b0000, 4'b0100, 4'b0000, 2'd0};
    tbl[3]  = '{4'b1001, 4'b0000, 4'b0000, 2'd0};
    tbl[4]  = '{4'b1001, 4'b0000, 4'b1000, 2'd3};
    tbl[5]  = '{4'b1001, 4'b0001, 4'b1000, 2'd3};
    tbl[6]  = '{4'b1001, 4'b1000, 4'b0000, 2'd0};
    tbl[7]  = '{4'b1001, 4'b0000, 4'b0000, 2'd0};
    tbl[8]  = '{4'b1001, 4'b0000, 4'b0001, 2'd0};
    tbl[9]  = '{4'b0010, 4'b0001, 4'b0000, 2'd0};
    tbl[10] = '{4'b0010, 4'b0010, 4'b0000, 2'd0};
    tbl[11] = '{4'b0010, 4'b0000, 4'b0010, 2'd1};
    tbl[12] = '{4'b0000, 4'b1000, 4'b0010, 2'd1};
    tbl[13] = '{4'b0000, 4'b0000, 4'b0010, 2'd1};
    tbl[14] = '{4'b0010, 4'b0010, 4'b0000, 2'd0};
    tbl[15] = '{4'b0011, 4'b0000, 4'b0000, 2'd0};
    tbl[16] = '{4'b0011, 4'b0000, 4'b0001, 2'd0};
    tbl[17] = '{4'b0000, 4'b0001, 4'b0000, 2'd0};
    tbl[18] = '{4'b0000, 4'b0000, 4'b0000, 2'd0};
    tbl[19] = '{4'b0000, 4'b0000, 4'b0000, 2'd0};

    do_reset();
    chk("reset_gnt", gnt, 4'b0000);
    chk("reset_valid", gnt_valid, 1'b0);
    chk("reset_idx", gnt_idx, 2'd0);
    chk("reset_terr", timeout_err, 1'b0);

    for (int i = 0; i < 20; i++) begin
      step(tbl[i].req, tbl[i].done);
      chk($sformatf("vec%0d_gnt", i), gnt, tbl[i].gnt);
      chk($sformatf("vec%0d_valid", i), gnt_valid, |tbl[i].gnt);
      chk($sformatf("vec%0d_idx", i), gnt_idx, tbl[i].idx);
      chk($sformatf("vec%0d_terr", i), timeout_err, 1'b0);
    end

    // All requesting: strict rotation, owner releases 3 cycles after its grant
    do_reset();
    fall_edge = 0;
    for (int e = 0; e < 5; e++) begin
      exp_g = 4'b0001 << (e % 4);
      w = 0;
      while (gnt == 4'b0000 && w < 4) begin
        step(4'b1111, 4'b0000);
        w++;
      end
      chk($sformatf("rr%0d_owner", e), gnt, exp_g);
      if (e > 0) chk($sformatf("rr%0d_gap_edges", e), edges - fall_edge, 2);
      step(4'b1111, 4'b0000);
      step(4'b1111, 4'b0000);
      chk($sformatf("rr%0d_hold", e), gnt, exp_g);
      step(4'b1111, exp_g);
      chk($sformatf("rr%0d_release", e), gnt, 4'b0000);
      fall_edge = edges;
    end

    // Asynchronous reset while node 1 owns the bus
    do_reset();
    step(4'b0010, 4'b0000);
    chk("prerst_gnt", gnt, 4'b0010);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("asyncrst_gnt", gnt, 4'b0000);
    chk("asyncrst_valid", gnt_valid, 1'b0);
    chk("asyncrst_idx", gnt_idx, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b0011, 4'b0000);
    chk("postrst_gnt", gnt, 4'b0001);
    chk("postrst_idx", gnt_idx, 2'd0);

`ifdef SNOOP_ARB_TIMEOUT_EN
    // Owner never completes: forced release after 8 cycles of ownership
    do_reset();
    step(4'b0011, 4'b0000);
    w = 0;
    while (gnt == 4'b0001 && w < 20) begin
      w++;
      step(4'b0011, 4'b0000);
    end
    chk("to_hold_cycles", w, 8);
    chk("to_gnt_dropped", gnt, 4'b0000);
    chk("to_err_pulse", timeout_err, 1'b1);
    step(4'b0011, 4'b0000);
    chk("to_err_cleared", timeout_err, 1'b0);
    chk("to_turn_gnt", gnt, 4'b0000);
    step(4'b0011, 4'b0000);
    chk("to_next_owner", gnt, 4'b0010);
`else
    // Without the timeout the grant is held indefinitely
    do_reset();
    step(4'b0011, 4'b0000);
    w = 0;
    for (int k = 0; k < 20; k++) begin
      step(4'b0011, 4'b0000);
      if (gnt == 4'b0001 && timeout_err == 1'b0) w++;
    end
    chk("hold_no_timeout_cycles", w, 20);
    chk("hold_no_timeout_gnt", gnt, 4'b0001);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/snoop_arbiter.md
Name: snoop_arbiter

Overview:
- Round-robin arbiter for the shared snoop bus; sits directly upstream of the snoop bus mux and drives its one-hot grant vector.
- Each cache controller raises a request, holds the bus for an arbitrary-length transaction, and signals completion.
- The arbiter guarantees a registered, glitch-free one-hot grant, fair rotation, and one idle turnaround cycle between owners, which the registered bus output needs.

Parameters:
- NUM_NODES, default NUM_CACHE (cache_types), number of bus requesters; legal range 2..16.
- IDX, default $clog2(NUM_NODES), width of the binary grant index; derived, do not override.
- TIMEOUT_CYCLES, default 64, maximum grant hold length in cycles. Used only when SNOOP_ARB_TIMEOUT_EN is defined; legal range 2..65535.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- req  input  NUM_NODES  per-node bus request, level-sensitive
- done  input  NUM_NODES  per-node transaction-complete pulse; only the current owner's bit counts
- gnt  output  NUM_NODES  registered one-hot grant (onehot0); feeds the snoop bus mux
- gnt_valid  output  1  registered; high exactly when gnt != 0
- gnt_idx  output  IDX  registered binary index of the current owner; 0 when gnt_valid=0
- timeout_err  output  1  one-cycle pulse on a forced release; tied 0 without SNOOP_ARB_TIMEOUT_EN

Behaviour:
- Reset (async assert, sync release): state=IDLE, gnt=0, gnt_valid=0, gnt_idx=0, ptr=0, timeout_err=0, hold counter=0. Reset mid-grant drops gnt immediately, with no completion semantics.
- State machine has three states: IDLE, OWN, TURN.
- IDLE:
  - When any req bit is 1 at a rising edge, the winner is the first set bit searching ptr, ptr+1, ..., wrapping modulo NUM_NODES.
  - At that edge: gnt=onehot(winner), gnt_idx=winner, gnt_valid=1, state->OWN.
  - Latency from req sampled high to gnt high is 1 cycle. With no req, stay in IDLE.
- OWN:
  - Grant is held regardless of req; dropping req does not release.
  - At an edge with done[gnt_idx]=1: gnt=0, gnt_valid=0, gnt_idx=0, ptr=(gnt_idx+1) mod NUM_NODES (wrap NUM_NODES-1->0), state->TURN.
  - done bits of non-owners are ignored in every state. done in IDLE or TURN is ignored.
- TURN:
  - Exactly one cycle with no grant, then state->IDLE unconditionally.
  - Minimum gap between one owner's gnt falling and the next gnt rising is 2 edges, i.e. one full cycle with gnt=0 seen by the bus.
- Fairness: a continuously requesting node is granted within NUM_NODES-1 other tenures.
- Simultaneous events:
  - done and a new req from the same node in the same cycle: release happens, and ptr has advanced past that node.
  - All req high: strict rotation 0,1,...,N-1,0.
- gnt is never multi-hot. gnt_valid == |gnt and gnt_idx matches gnt in every cycle. Implementation carries an onehot0 assertion on gnt plus this consistency assertion.
- No combinational path from req or done to any output.

Optional Feature:
- Macro SNOOP_ARB_TIMEOUT_EN.
- Defined:
  - A hold counter clears on entry to OWN and increments each cycle in OWN.
  - If the counter reaches TIMEOUT_CYCLES-1 without done, the next edge forces release exactly as a done would (ptr advances, state->TURN) and pulses timeout_err for one cycle.
  - done on the same edge as the timeout counts as a normal release, with no timeout_err.
- Undefined: no counter is built, the grant is held indefinitely until done, and timeout_err is tied 0.

Test Plan:
- Reset then req=4'b0100 (N=4) -> gnt=4'b0100, gnt_idx=2 one cycle later. done[2] pulse -> gnt=0 next edge, one idle cycle, ptr=3.
- req=4'b1111 held, each owner pulses done 3 cycles after its grant -> grant order 0,1,2,3,0; exactly one gnt=0 cycle between tenures; never multi-hot.
- Owner 1 drops req while granted, and done[3] is pulsed by non-owner 3 -> gnt stays 4'b0010 until done[1].
- ptr=3 with req=4'b1001 -> node 3 granted first, then node 0 (wrap).
- rst_n asserted low mid-OWN with gnt=4'b0010 -> gnt=0 and gnt_valid=0 immediately (asynchronous). After release, req=4'b0011 -> node 0 granted (ptr=0).
- SNOOP_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, owner never asserts done -> gnt drops after 8 cycles of ownership, timeout_err=1 for one cycle, next requester granted after the turnaround cycle.
